mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
- Memory-mapped I/O controller between the cpu load/store port and the board peripherals: ps2_kbd, the switches, the serial seg display and the leds.
- Decodes word addresses and serialises accesses, one outstanding request at a time.
- Sequences the keyboard pop handshake (active-low read strobe).
- Holds the seg and led output registers that feed the display and led pins.

Parameters:
- BASE, 32'hA000_0000, MMIO window base; bits [31:8] must match.
- KB_TIMEOUT, 1024, max cycles a blocking keyboard read waits for data.
- DB_CYCLES, 16, switch debounce stability count.

Ports:
- clk  in  1  system clock (the same divided clock that drives cpu)
- clrn  in  1  asynchronous active-low reset
- req_valid  in  1  cpu request valid
- req_ready  out  1  controller accepts request
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address, word aligned
- req_wdata  in  32  store data
- req_wstrb  in  4  byte enables for store
- rsp_valid  out  1  response valid
- rsp_ready  in  1  cpu accepts response
- rsp_rdata  out  32  load data
- rsp_err  out  1  unmapped/illegal access
- kb_data  in  8  ps2_kbd fifo head
- kb_ready  in  1  ps2_kbd fifo non-empty
- kb_overflow  in  1  ps2_kbd overflow
- kb_rdn  out  1  active-low pop strobe to ps2_kbd
- swt  in  8  raw switch pins
- seg_wdata  out  32  seg display value
- led_wdata  out  8  led value

Behaviour:
- Register map (offset from BASE):
  - 0x00 KB_DATA, R: {22'b0, valid, 1'b0, data[7:0]}, pops the fifo.
  - 0x04 KB_STAT, R: {30'b0, ovf_sticky, kb_ready}. W: bit1=1 clears ovf_sticky.
  - 0x08 KB_BLK, R: blocking read; waits up to KB_TIMEOUT.
  - 0x0C SWT, R: {24'b0, swt_db}.
  - 0x10 SEG, R/W: byte-strobed.
  - 0x14 LED, R/W: wstrb[0] only.
  - Any other offset, misaligned addr[1:0]!=0, or store to 0x00/0x08/0x0C: rsp_err=1, rdata=0, no side effect.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, kb_rdn=1, seg_wdata=0, led_wdata=0, ovf_sticky=0, swt_db=0, state IDLE.
- FSM states: IDLE, KB_WAIT, KB_POP, RESP.
- IDLE: req_ready=1. Handshake req_valid&req_ready.
  - Register access: act, latch rdata/err, go to RESP. Latency 1 cycle to rsp_valid.
  - KB_DATA with kb_ready=1: capture kb_data, valid=1, go to KB_POP.
  - KB_DATA with kb_ready=0: valid=0, data=0, go to RESP. No pop.
  - KB_BLK: go to KB_WAIT and load the timeout counter with KB_TIMEOUT-1.
- KB_WAIT: req_ready=0.
  - kb_ready=1: capture, go to KB_POP.
  - Counter==0: go to RESP with valid=0, rsp_err=0.
  - Otherwise decrement the counter.
- KB_POP: kb_rdn=0 for exactly one cycle, then go to RESP. KB_DATA with data pops in 2 cycles to rsp_valid.
- RESP: rsp_valid=1; rdata/err held stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE. req_ready=0 outside IDLE.
- kb_rdn is registered. Never low outside KB_POP. At most one pop per request.
- ovf_sticky:
  - Set on kb_overflow=1.
  - A set in the same cycle as a clear wins.
- Switches: swt goes through a 2-flop synchronizer. swt_db updates a bit only after DB_CYCLES consecutive equal samples (one counter per bit).
- seg_wdata/led_wdata update on the cycle after the accepted store and are visible to the peripherals immediately.
- clrn asserted mid-operation (any state): immediate return to reset values. kb_rdn=1, so an in-flight pop is aborted; the fifo keeps its head byte.

Decomposition:
- mmio_pkg holds:
  - Offset constants OFF_KB_DATA..OFF_LED.
  - State enum mmio_state_t {IDLE, KB_WAIT, KB_POP, RESP}.
  - Field widths KB_W=8, LED_W=8, SEG_W=32.
- One sub-module: swt_sync, the synchronizer plus per-bit debounce, parameter DB_CYCLES, with ports clk, clrn, swt, swt_db.

Test Plan:
- Reset: hold clrn=0 with random inputs -> req_ready=1, rsp_valid=0, kb_rdn=1, seg_wdata=0, led_wdata=0.
- Store 0x1234_5678 to SEG with wstrb=4'b0101, then load SEG -> seg_wdata=0x0034_0078; rsp_rdata=0x0034_0078, err=0.
- kb_ready=1, kb_data=0x1C, load KB_DATA -> kb_rdn low exactly 1 cycle; rsp_rdata=0x0000_021C after 2 cycles. With kb_ready=0 -> rdata=0, no kb_rdn pulse.
- Load KB_BLK with KB_TIMEOUT=8, kb_ready rises at cycle 5 -> pop, rdata valid=1. A repeat with no data -> rdata=0 after 8 wait cycles, err=0.
- Store to 0x0C and load of 0x18 -> rsp_err=1, rdata=0, registers unchanged. Hold rsp_ready=0 for 3 cycles -> rsp_valid/rdata stable, req_ready=0.
- Drop clrn during KB_WAIT -> state IDLE, kb_rdn stays 1. Toggle swt[3] for 10 cycles then hold -> swt_db[3] changes only after 16 stable cycles plus sync latency.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants, types and helpers for the MMIO controller.
//   - Register offsets inside the MMIO window
//   - FSM state encoding and decoded-target encoding
//   - Field widths for keyboard, switch, led and seg registers
package mmio_pkg;

  localparam int KB_W  = 8;
  localparam int LED_W = 8;
  localparam int SEG_W = 32;
  localparam int SWT_W = 8;

  localparam logic [7:0] OFF_KB_DATA = 8'h00;
  localparam logic [7:0] OFF_KB_STAT = 8'h04;
  localparam logic [7:0] OFF_KB_BLK  = 8'h08;
  localparam logic [7:0] OFF_SWT     = 8'h0C;
  localparam logic [7:0] OFF_SEG     = 8'h10;
  localparam logic [7:0] OFF_LED     = 8'h14;

  typedef enum logic [1:0] {IDLE, KB_WAIT, KB_POP, RESP} mmio_state_t;

  // Which register a request hits; T_ERR covers every illegal access
  // (outside the window, misaligned, unmapped, store to a read-only reg).
  typedef enum logic [2:0] {
    T_KB_DATA, T_KB_STAT, T_KB_BLK, T_SWT, T_SEG, T_LED, T_ERR
  } mmio_tgt_t;

  function automatic mmio_tgt_t mmio_decode(input logic [31:0] addr,
                                            input logic        we,
                                            input logic [23:0] base_hi);
    mmio_tgt_t t;
    t = T_ERR;
    if (addr[31:8] == base_hi && addr[1:0] == 2'b00) begin
      case (addr[7:0])
        OFF_KB_DATA: t = we ? T_ERR : T_KB_DATA;
        OFF_KB_STAT: t = T_KB_STAT;
        OFF_KB_BLK:  t = we ? T_ERR : T_KB_BLK;
        OFF_SWT:     t = we ? T_ERR : T_SWT;
        OFF_SEG:     t = T_SEG;
        OFF_LED:     t = T_LED;
        default:     t = T_ERR;
      endcase
    end
    return t;
  endfunction

  function automatic logic [SEG_W-1:0] byte_merge(input logic [SEG_W-1:0] old,
                                                  input logic [31:0]      wdata,
                                                  input logic [3:0]       strb);
    logic [SEG_W-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

  // Keyboard load word: {22'b0, valid, 1'b0, data}
  function automatic logic [31:0] kb_word(input logic vld, input logic [KB_W-1:0] data);
    return {22'b0, vld, 1'b0, data};
  endfunction

endpackage

// File: rtl/swt_sync.sv
// swt_sync: 2-flop synchronizer followed by a per-bit debouncer.
//   clk    : system clock
//   clrn   : async active-low reset
//   swt    : raw switch pins
//   swt_db : debounced switch value; a bit takes a new value only after
//            DB_CYCLES consecutive synchronized samples differ from it.
module swt_sync
  import mmio_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [SWT_W-1:0] swt,
  output logic [SWT_W-1:0] swt_db
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

  logic [SWT_W-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= swt;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < SWT_W; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          db_q;

    // cnt counts consecutive samples that disagree with db_q; any agreeing
    // sample restarts the run.
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        cnt  <= '0;
        db_q <= 1'b0;
      end else if (sync2[i] == db_q) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt  <= '0;
        db_q <= sync2[i];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign swt_db[i] = db_q;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: MMIO controller between the cpu load/store port and the board
// peripherals (ps2 keyboard fifo, switches, seg display, leds).
//   clk, clrn                      : clock, async active-low reset
//   req_valid/ready/we/addr/wdata/wstrb : cpu request channel
//   rsp_valid/ready/rdata/err      : cpu response channel
//   kb_data/kb_ready/kb_overflow   : keyboard fifo head, non-empty, overflow
//   kb_rdn                         : registered active-low pop strobe
//   swt                            : raw switch pins
//   seg_wdata, led_wdata           : display and led output registers
// One request is in flight at a time; req_ready is high only in IDLE.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'hA000_0000,
  parameter int          KB_TIMEOUT = 1024,
  parameter int          DB_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  input  logic [KB_W-1:0]  kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_rdn,
  input  logic [SWT_W-1:0] swt,
  output logic [SEG_W-1:0] seg_wdata,
  output logic [LED_W-1:0] led_wdata
);

  localparam int CNT_W = (KB_TIMEOUT > 1) ? $clog2(KB_TIMEOUT) : 1;

  mmio_state_t      state;
  logic [CNT_W-1:0] kb_cnt;
  logic             ovf_sticky;
  logic [SWT_W-1:0] swt_db;
  mmio_tgt_t        tgt;
  logic [31:0]      rd_val;
  logic             ovf_clr;

  swt_sync #(.DB_CYCLES(DB_CYCLES)) u_swt_sync (
    .clk    (clk),
    .clrn   (clrn),
    .swt    (swt),
    .swt_db (swt_db)
  );

  assign tgt     = mmio_decode(req_addr, req_we, BASE[31:8]);
  assign ovf_clr = (state == IDLE) && req_valid && (tgt == T_KB_STAT) &&
                   req_we && req_wstrb[0] && req_wdata[1];

  // Load data for the plain registers; keyboard reads are handled in the FSM.
  always_comb begin
    rd_val = '0;
    case (tgt)
      T_KB_STAT: rd_val = {30'b0, ovf_sticky, kb_ready};
      T_SWT:     rd_val = {{(32-SWT_W){1'b0}}, swt_db};
      T_SEG:     rd_val = seg_wdata;
      T_LED:     rd_val = {{(32-LED_W){1'b0}}, led_wdata};
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      kb_rdn     <= 1'b1;
      kb_cnt     <= '0;
      seg_wdata  <= '0;
      led_wdata  <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      // A set in the same cycle as a clear must win.
      if (kb_overflow)  ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= req_we ? 32'h0 : rd_val;
            rsp_valid <= 1'b1;
            state     <= RESP;
            case (tgt)
              T_KB_DATA: begin
                if (kb_ready) begin
                  rsp_rdata <= kb_word(1'b1, kb_data);
                  kb_rdn    <= 1'b0;
                  rsp_valid <= 1'b0;
                  state     <= KB_POP;
                end else begin
                  rsp_rdata <= '0;
                end
              end
              T_KB_BLK: begin
                rsp_rdata <= '0;
                rsp_valid <= 1'b0;
                kb_cnt    <= CNT_W'(KB_TIMEOUT - 1);
                state     <= KB_WAIT;
              end
              T_SEG: if (req_we) seg_wdata <= byte_merge(seg_wdata, req_wdata, req_wstrb);
              T_LED: if (req_we && req_wstrb[0]) led_wdata <= req_wdata[LED_W-1:0];
              T_ERR: begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
              end
              default: ;
            endcase
          end
        end
        KB_WAIT: begin
          if (kb_ready) begin
            rsp_rdata <= kb_word(1'b1, kb_data);
            kb_rdn    <= 1'b0;
            state     <= KB_POP;
          end else if (kb_cnt == '0) begin
            // Timed out: valid=0, not an error.
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            kb_cnt <= kb_cnt - CNT_W'(1);
          end
        end
        KB_POP: begin
          kb_rdn    <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          kb_rdn    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
module tb_mmio_ctrl;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'hA000_0000;
  localparam int KBT = 8;
  localparam int DBC = 16;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  kb_data = '0;
  logic        kb_ready = 1'b0, kb_overflow = 1'b0, kb_rdn;
  logic [7:0]  swt = '0;
  logic [31:0] seg_wdata;
  logic [7:0]  led_wdata;

  mmio_ctrl #(.BASE(BASE), .KB_TIMEOUT(KBT), .DB_CYCLES(DBC)) dut (
    .clk(clk), .clrn(clrn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .kb_data(kb_data), .kb_ready(kb_ready), .kb_overflow(kb_overflow), .kb_rdn(kb_rdn),
    .swt(swt), .seg_wdata(seg_wdata), .led_wdata(led_wdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];
  logic [31:0] seg_m = '0;
  logic [7:0]  led_m = '0, swt_m = '0;
  logic        ovf_m = 1'b0;

  // kb_avail: a keyboard byte is (or becomes, within the timeout) available.
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic kb_avail, input logic [7:0] kb_byte);
    exp_t e;
    logic [31:0] off;
    e.rdata = 0; e.err = 0;
    off = addr % 256;
    if ((addr >> 8) != (BASE >> 8) || (addr % 4) != 0) e.err = 1;
    else case (off)
      0, 8: if (we) e.err = 1; else if (kb_avail) e.rdata = 512 + kb_byte;
      4:    if (we) begin if (strb[0] && wdata[1]) ovf_m = 0; end
            else e.rdata = 2 * ovf_m + kb_avail;
      12:   if (we) e.err = 1; else e.rdata = swt_m;
      16:   if (we) begin
              for (int b = 0; b < 4; b++)
                if (strb[b]) seg_m = (seg_m & ~(32'hFF << (8*b))) | (wdata & (32'hFF << (8*b)));
            end else e.rdata = seg_m;
      20:   if (we) begin if (strb[0]) led_m = wdata % 256; end
            else e.rdata = led_m;
      default: e.err = 1;
    endcase
    return e;
  endfunction

  // ---------------- response backpressure ----------------
  logic hold_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  logic        pv = 0, pr = 0, pe = 0;
  logic [31:0] prd = 0;
  exp_t        me;
  int          pop_cnt = 0;

  always @(negedge clk) begin
    if (!clrn) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("hold_rsp_rdata", rsp_rdata, prd);
        chk("hold_rsp_err", {31'b0, rsp_err}, {31'b0, pe});
        chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rsp: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
        end else begin
          me = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, me.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, me.err});
        end
      end
      pv = rsp_valid; pr = rsp_ready; prd = rsp_rdata; pe = rsp_err;
    end
  end

  always @(negedge clk) if (kb_rdn === 1'b0) pop_cnt++;

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic kb_avail, input logic [7:0] kb_byte);
    int n;
    exp_q.push_back(model(we, addr, wdata, strb, kb_avail, kb_byte));
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      if (++n > 200) begin
        n_chk++; n_fail++;
        $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  // Cycles from the accepting edge to rsp_valid (1 = visible right after it).
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (++lat > 3000) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_valid_timeout: got 0 expected 1");
        break;
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic kb_avail, input logic [7:0] kb_byte,
                      input string name);
    int lat, p0, exp_lat;
    logic legal, kbrd;
    legal = (addr[31:8] == BASE[31:8]) && (addr[1:0] == 2'b00);
    kbrd  = legal && !we && (addr[7:0] == 8'h00 || addr[7:0] == 8'h08);
    exp_lat = (kbrd && kb_avail) ? 2 : (kbrd && addr[7:0] == 8'h08) ? KBT + 1 : 1;
    kb_ready = kb_avail; kb_data = kb_byte;
    p0 = pop_cnt;
    issue(we, addr, wdata, strb, kb_avail, kb_byte);
    wait_rsp(lat);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    wait_done();
    chk({name, "_pops"}, 32'(pop_cnt - p0), {31'b0, kbrd && kb_avail});
    chk({name, "_seg_wdata"}, seg_wdata, seg_m);
    chk({name, "_led_wdata"}, {24'b0, led_wdata}, {24'b0, led_m});
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] offs [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};

  initial begin
    int p0;
    logic [31:0] a;
    logic [7:0] s;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = BASE + ($urandom % 32);
      req_wdata = $urandom; req_wstrb = 4'($urandom); kb_ready = 1'($urandom);
      kb_data = 8'($urandom); kb_overflow = 1'($urandom); swt = 8'($urandom);
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_kb_rdn", {31'b0, kb_rdn}, 32'd1);
      chk("rst_seg", seg_wdata, 32'd0);
      chk("rst_led", {24'b0, led_wdata}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 0; kb_ready = 0; kb_overflow = 0; swt = 0;
    clrn = 1;
    repeat (2) @(posedge clk); #1;

    // SEG byte strobes
    xact(1, BASE + 32'h10, 32'h1234_5678, 4'b0101, 0, 0, "seg_store");
    chk("seg_value", seg_wdata, 32'h0034_0078);
    xact(0, BASE + 32'h10, 0, 0, 0, 0, "seg_load");
    // LED only takes wstrb[0]
    xact(1, BASE + 32'h14, 32'hFFFF_FFA5, 4'b1110, 0, 0, "led_nostrb");
    xact(1, BASE + 32'h14, 32'h0000_00A5, 4'b0001, 0, 0, "led_store");
    xact(0, BASE + 32'h14, 0, 0, 0, 0, "led_load");

    // Keyboard non-blocking read
    xact(0, BASE + 32'h00, 0, 0, 1, 8'h1C, "kb_data_pop");
    xact(0, BASE + 32'h00, 0, 0, 0, 8'h33, "kb_data_empty");

    // Blocking read, data arrives 5 cycles after acceptance
    kb_ready = 0; kb_data = 8'h5A;
    p0 = pop_cnt;
    issue(0, BASE + 32'h08, 0, 0, 1, 8'h5A);
    repeat (4) @(posedge clk); #1;
    kb_ready = 1;
    wait_done();
    kb_ready = 0;
    chk("kb_blk_data_pops", 32'(pop_cnt - p0), 32'd1);
    // Blocking read timeout
    xact(0, BASE + 32'h08, 0, 0, 0, 0, "kb_blk_timeout");

    // Illegal accesses
    xact(1, BASE + 32'h0C, 32'hDEAD_BEEF, 4'hF, 0, 0, "err_store_swt");
    xact(0, BASE + 32'h18, 0, 0, 0, 0, "err_load_unmapped");
    xact(1, BASE + 32'h12, 32'hFFFF_FFFF, 4'hF, 0, 0, "err_misaligned");
    xact(1, 32'hB000_0010, 32'hFFFF_FFFF, 4'hF, 0, 0, "err_outside");
    xact(1, BASE + 32'h00, 32'h1, 4'hF, 1, 8'h11, "err_store_kbdata");
    xact(1, BASE + 32'h08, 32'h1, 4'hF, 1, 8'h11, "err_store_kbblk");
    xact(0, BASE + 32'h10, 0, 0, 0, 0, "seg_after_err");

    // Response held under backpressure
    hold_rdy = 1;
    issue(0, BASE + 32'h10, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    hold_rdy = 0;
    wait_done();

    // Overflow sticky: set, set-beats-clear, clear
    @(posedge clk); #1 kb_overflow = 1;
    @(posedge clk); #1 kb_overflow = 0;
    ovf_m = 1;
    xact(0, BASE + 32'h04, 0, 0, 1, 0, "ovf_set");
    kb_overflow = 1;
    xact(1, BASE + 32'h04, 32'h2, 4'h1, 0, 0, "ovf_clr_vs_set");
    ovf_m = 1;
    kb_overflow = 0;
    xact(0, BASE + 32'h04, 0, 0, 0, 0, "ovf_kept");
    xact(1, BASE + 32'h04, 32'h2, 4'h1, 0, 0, "ovf_clear");
    xact(0, BASE + 32'h04, 0, 0, 0, 0, "ovf_cleared");

    // Switch debounce
    s = 8'($urandom) & 8'hF7;
    swt = s; swt_m = s;
    repeat (40) @(posedge clk); #1;
    xact(0, BASE + 32'h0C, 0, 0, 0, 0, "swt_settled");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 swt = swt ^ 8'h08;
    end
    @(posedge clk); #1 swt = s | 8'h08;
    repeat (5) @(posedge clk); #1;
    xact(0, BASE + 32'h0C, 0, 0, 0, 0, "swt_not_yet");
    repeat (30) @(posedge clk); #1;
    swt_m = s | 8'h08;
    xact(0, BASE + 32'h0C, 0, 0, 0, 0, "swt_debounced");

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      a = BASE + offs[$urandom_range(0, 7)];
      case ($urandom_range(0, 9))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = a ^ 32'h0100_0000;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1 kb_overflow = 1;
        @(posedge clk); #1 kb_overflow = 0;
        ovf_m = 1;
      end
      xact(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom), 8'($urandom), "rand");
    end

    // Reset while waiting on the keyboard
    kb_ready = 0;
    issue(0, BASE + 32'h08, 0, 0, 0, 0);
    repeat (3) @(posedge clk); #1;
    clrn = 0;
    #1;
    exp_q.delete();
    seg_m = 0; led_m = 0; ovf_m = 0;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_kb_rdn", {31'b0, kb_rdn}, 32'd1);
    chk("midrst_seg", seg_wdata, seg_m);
    chk("midrst_led", {24'b0, led_wdata}, {24'b0, led_m});
    @(posedge clk); #1 clrn = 1;
    xact(0, BASE + 32'h04, 0, 0, 0, 0, "after_rst_stat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
